rom_loader: RTL and testbench

Boot-time instruction-memory writer for `riscv_core`. Receives a program image as a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. Writes each word to the write port of the instruction ROM (`u_rom.u_gnrl_rom`), which the core's fetch stage reads. Holds the core in reset until the image is fully loaded, replacing `$readmemb` backdoor loading with a synthesizable front-door path.

---
 rtl/rom_loader.sv | 141 ++++++++++++++
 tb/tb_rom_loader.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_loader.sv
// rtl/rom_loader.sv - byte-stream loader writing 32-bit words into the instruction ROM and releasing core reset
// Optional feature macro: ROM_LOADER_CHKSUM_EN (final word is a checksum, not written).
module rom_loader #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_data,
    input  logic                  in_last,
    output logic                  rom_we,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic [31:0]           rom_wdata,
    output logic                  core_rstn,
    output logic                  load_done,
    output logic                  load_err,
    output logic [ADDR_WIDTH:0]   word_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

`ifdef ROM_LOADER_CHKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    state_t     state;
    state_t     state_nxt;
    logic [1:0] byte_idx;
    logic       last_word;
    logic       accept;
    logic       full;
    logic       start;
    logic       write_word;
    logic       word_ok;

    assign accept     = in_valid && in_ready;
    assign full       = word_cnt[ADDR_WIDTH];
    assign start      = load_start && (state == S_IDLE || state == S_DONE || state == S_ERR);
    // The checksum word still passes through the WRITE slot but never reaches the ROM.
    assign write_word = (state == S_WRITE) && !(CHK_EN && last_word);

`ifdef ROM_LOADER_CHKSUM_EN
    logic [31:0] chk_sum;

    assign word_ok = (chk_sum + rom_wdata) == 32'd0;

    always_ff @(posedge clk) begin
        if (rst || start) begin
            chk_sum <= 32'd0;
        end else if (write_word) begin
            chk_sum <= chk_sum + rom_wdata;
        end
    end
`else
    assign word_ok = 1'b1;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (load_start) begin
                    state_nxt = S_RECV;
                end
            end
            S_RECV: begin
                if (accept) begin
                    if (full) begin
                        state_nxt = S_ERR;
                    end else if (byte_idx == 2'd3) begin
                        state_nxt = S_WRITE;
                    end else if (in_last) begin
                        state_nxt = S_ERR;
                    end
                end
            end
            S_WRITE: begin
                if (!last_word) begin
                    state_nxt = S_RECV;
                end else if (word_ok) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_ERR;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            byte_idx  <= 2'd0;
            last_word <= 1'b0;
            in_ready  <= 1'b0;
            rom_we    <= 1'b0;
            rom_addr  <= '0;
            rom_wdata <= 32'd0;
            core_rstn <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            word_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            // Outputs are decoded from the next state so they line up with the state register.
            in_ready  <= (state_nxt == S_RECV);
            rom_we    <= (state_nxt == S_WRITE) && !(CHK_EN && in_last);
            core_rstn <= (state_nxt == S_DONE);
            load_done <= (state_nxt == S_DONE);
            load_err  <= (state_nxt == S_ERR);

            if (start) begin
                byte_idx <= 2'd0;
                rom_addr <= '0;
                word_cnt <= '0;
            end else if (write_word) begin
                rom_addr <= rom_addr + ADDR_WIDTH'(1);
                word_cnt <= word_cnt + {{ADDR_WIDTH{1'b0}}, 1'b1};
            end

            if (accept && !full) begin
                rom_wdata[{byte_idx, 3'b000} +: 8] <= in_data;
                byte_idx <= byte_idx + 2'd1;
                if (byte_idx == 2'd3) begin
                    last_word <= in_last;
                end
            end
        end
    end

endmodule

// File: tb/tb_rom_loader.sv
// tb/tb_rom_loader.sv - randomized self-checking bench for rom_loader against a word-level image model
module tb_rom_loader;

    localparam int AW  = 2;
    localparam int CAP = 4;
`ifdef ROM_LOADER_CHKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          load_start;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_data;
    logic          in_last;
    logic          rom_we;
    logic [AW-1:0] rom_addr;
    logic [31:0]   rom_wdata;
    logic          core_rstn;
    logic          load_done;
    logic          load_err;
    logic [AW:0]   word_cnt;

    rom_loader #(.ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .load_start(load_start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .rom_we    (rom_we),
        .rom_addr  (rom_addr),
        .rom_wdata (rom_wdata),
        .core_rstn (core_rstn),
        .load_done (load_done),
        .load_err  (load_err),
        .word_cnt  (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc++;

    logic [7:0]  img[$];
    logic [31:0] exp_words[$];
    bit          exp_done;
    int          exp_cnt;
    logic [31:0] wr_data[$];
    int          wr_addr[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ROM sink: every write strobe is recorded; ready must be low whenever a write is presented.
    always @(negedge clk) begin
        if (rom_we) begin
            wr_data.push_back(rom_wdata);
            wr_addr.push_back(int'(rom_addr));
            check("ready_low_in_write", 64'(in_ready), 64'd0);
        end
    end

    // Image model: group bytes into little-endian words, then apply the load outcome rules.
    function automatic void model();
        int          n   = img.size();
        int          nw  = n / 4;
        logic [31:0] sum = 32'd0;
        logic [31:0] w[$];
        exp_words.delete();
        for (int k = 0; k < nw; k++)
            w.push_back({img[4*k+3], img[4*k+2], img[4*k+1], img[4*k]});
        if (n > 4 * CAP) begin
            exp_done = 1'b0;
            for (int k = 0; k < CAP; k++) exp_words.push_back(w[k]);
        end else if (n % 4 != 0) begin
            exp_done = 1'b0;
            exp_words = w;
        end else if (CHK) begin
            foreach (w[k]) sum += w[k];
            exp_done = (sum == 32'd0);
            for (int k = 0; k < nw - 1; k++) exp_words.push_back(w[k]);
        end else begin
            exp_done = 1'b1;
            exp_words = w;
        end
        exp_cnt = exp_words.size();
    endfunction

    task automatic pulse_start();
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit last, input int gap, output bit ok);
        int waitc = 0;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        in_last  = last;
        ok = 1'b0;
        while (!ok && waitc < 20) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
            waitc++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("byte_accepted", 64'(ok), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  64'(in_ready),  64'd0);
        check({tag, "_rom_we"},    64'(rom_we),    64'd0);
        check({tag, "_rom_addr"},  64'(rom_addr),  64'd0);
        check({tag, "_rom_wdata"}, 64'(rom_wdata), 64'd0);
        check({tag, "_core_rstn"}, 64'(core_rstn), 64'd0);
        check({tag, "_load_done"}, 64'(load_done), 64'd0);
        check({tag, "_load_err"},  64'(load_err),  64'd0);
        check({tag, "_word_cnt"},  64'(word_cnt),  64'd0);
    endtask

    task automatic run_load(input int max_gap, input string name);
        bit ok;
        bit we_exp;
        int acc0 = 0;
        int acc4 = 0;
        int w    = 0;
        int gap;
        model();
        wr_data.delete();
        wr_addr.delete();
        pulse_start();
        for (int i = 0; i < img.size(); i++) begin
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            send_byte(img[i], i == img.size() - 1, gap, ok);
            if (!ok) break;
            if (i == 0) acc0 = cyc;
            if (i == 4) acc4 = cyc;
            if (i % 4 == 3 && i < 4 * CAP) begin
                we_exp = !(CHK && i == img.size() - 1);
                check({name, "_we_latency"}, 64'(rom_we), 64'(we_exp));
                check({name, "_addr_in_write"}, 64'(rom_addr), 64'((i / 4) % CAP));
                @(posedge clk); #1;
                check({name, "_addr_after_write"}, 64'(rom_addr),
                      64'(we_exp ? ((i / 4) + 1) % CAP : (i / 4) % CAP));
                check({name, "_cnt_after_write"}, 64'(word_cnt), 64'(we_exp ? i / 4 + 1 : i / 4));
            end
        end
        if (max_gap == 0 && img.size() >= 8)
            check({name, "_throughput"}, 64'(acc4 - acc0), 64'd5);
        while (!(load_done || load_err) && w < 10) begin
            @(posedge clk); #1;
            w++;
        end
        check({name, "_load_done"}, 64'(load_done), 64'(exp_done));
        check({name, "_load_err"},  64'(load_err),  64'(!exp_done));
        check({name, "_core_rstn"}, 64'(core_rstn), 64'(exp_done));
        check({name, "_word_cnt"},  64'(word_cnt),  64'(exp_cnt));
        check({name, "_in_ready"},  64'(in_ready),  64'd0);
        check({name, "_n_writes"},  64'(wr_data.size()), 64'(exp_words.size()));
        for (int k = 0; k < wr_data.size() && k < exp_words.size(); k++) begin
            check({name, "_wr_addr"}, 64'(wr_addr[k]), 64'(k));
            check({name, "_wr_data"}, 64'(wr_data[k]), 64'(exp_words[k]));
        end
    endtask

    task automatic set_demo_image();
        img = '{8'h13, 8'h0E, 8'h10, 8'h00,
                8'h93, 8'h0E, 8'h20, 8'h00,
                8'h13, 8'h0F, 8'h3E, 8'h00};
    endtask

    task automatic push_word(input logic [31:0] wd);
        img.push_back(wd[7:0]);
        img.push_back(wd[15:8]);
        img.push_back(wd[23:16]);
        img.push_back(wd[31:24]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ok;
        int          nw;
        logic [31:0] wd;
        logic [31:0] sum;
        rst        = 1'b1;
        load_start = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        in_last    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_core_rstn", 64'(core_rstn), 64'd0);

        set_demo_image();
        run_load(0, "demo");

        // Stream activity outside RECV must be ignored.
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("after_done_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("after_done_writes", 64'(wr_data.size()), 64'(exp_words.size()));
        check("after_done_cnt", 64'(word_cnt), 64'(exp_cnt));

        set_demo_image();
        run_load(3, "demo_gaps");

        img = '{8'h13, 8'h0E, 8'h10, 8'h00, 8'h93, 8'h0E};
        run_load(0, "partial");
        set_demo_image();
        run_load(0, "reload");

        img.delete();
        for (int k = 0; k < 4 * CAP + 1; k++) img.push_back(8'($urandom));
        run_load(1, "overflow");

        wr_data.delete();
        wr_addr.delete();
        pulse_start();
        for (int k = 0; k < 6; k++) send_byte(8'($urandom), 1'b0, 0, ok);
        check("pre_rst_writes", 64'(wr_data.size()), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("mid_rst");
        rst = 1'b0;
        @(posedge clk); #1;
        set_demo_image();
        run_load(0, "after_rst");

`ifdef ROM_LOADER_CHKSUM_EN
        img.delete();
        push_word(32'h00000001);
        push_word(32'h00000002);
        push_word(32'hFFFFFFFD);
        run_load(0, "chk_good");
        img.delete();
        push_word(32'h00000001);
        push_word(32'h00000002);
        push_word(32'hFFFFFFFE);
        run_load(0, "chk_bad");
        img.delete();
        push_word(32'h00000000);
        run_load(0, "chk_only");
`endif

        for (int it = 0; it < 12; it++) begin
            img.delete();
            nw  = int'($urandom_range(1, CAP));
            sum = 32'd0;
            for (int k = 0; k < nw; k++) begin
                wd = $urandom;
                if (CHK && k == nw - 1 && ($urandom_range(0, 3) != 0)) wd = -sum;
                sum += wd;
                push_word(wd);
            end
            run_load(int'($urandom_range(0, 3)), "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
